max7219_chain_driver: RTL

Drives a daisy-chain of NUM_DEV MAX7219 LED drivers over a 3-wire SPI-style link (spi_clk/dout/cs) from a single system clock. It runs a fixed init sequence, then continuously refreshes DIGITS digit registers per device from a double-buffered frame, with a valid/ready frame handshake. Runtime intensity and shutdown changes are inserted between refresh transactions. It sits between display-content logic and the board's LED module pins.

---
 rtl/max7219_chain_driver.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/max7219_chain_driver.sv
// MAX7219 daisy-chain driver: fixed init, then continuous digit refresh
// from a double-buffered frame with inserted intensity/shutdown writes.
module max7219_chain_driver #(
  parameter int          NUM_DEV = 4,
  parameter int          DIGITS  = 8,
  parameter int          CLK_DIV = 25,
  parameter int          CS_GAP  = 8,
  parameter logic [7:0]  DECODE  = 8'h00
) (
  input  logic                        clk,
  input  logic                        reset_sw,
  input  logic [NUM_DEV*DIGITS*8-1:0] frame,
  input  logic                        frame_valid,
  output logic                        frame_ready,
  input  logic [3:0]                  intensity,
  input  logic                        shutdown,
  output logic                        spi_clk,
  output logic                        dout,
  output logic                        cs,
  output logic                        init_done,
  output logic                        pass_done
);

  localparam int FW   = NUM_DEV * DIGITS * 8;
  localparam int L    = 16 * NUM_DEV;
  localparam int PH_N = 2 * L + CS_GAP;
  localparam int PHW  = $clog2(PH_N + 1);
  localparam int DW   = $clog2(CLK_DIV + 1);
  localparam int GW   = $clog2(DIGITS + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_TEST, S_SCAN, S_DECODE,
    S_INTEN, S_SHDN, S_DIGIT
  } kind_t;

  kind_t          cur, nxt, arb;
  logic [DW-1:0]  div;
  logic [PHW-1:0] ph, ph_n;
  logic [GW-1:0]  dig, dig_n;
  logic [L-1:0]   sr, word;
  logic [FW-1:0]  pend, act, act_src;
  logic [3:0]     int_q, addr;
  logic           shd_q;
  logic [15:0]    w16;
  logic           tick, start, last_dig, bnd, xfer, accept;

  always_comb begin
    tick     = (div == DW'(CLK_DIV - 1));
    last_dig = (dig == GW'(DIGITS - 1));
    start    = (cur == S_IDLE) || (tick && ph == PHW'(PH_N - 1));
    ph_n     = ph + PHW'(1);
    // pass boundary: end of last digit, or end of the init sequence
    bnd      = (cur == S_DIGIT && last_dig) ||
               (cur == S_SHDN && !init_done);
    xfer     = start && bnd && !frame_ready;
    accept   = frame_valid && frame_ready;
    act_src  = xfer ? pend : act;
    dig_n    = dig;
    if (cur == S_DIGIT)
      dig_n = last_dig ? '0 : dig + GW'(1);
    arb = S_DIGIT;
    if (shutdown != shd_q)
      arb = S_SHDN;
    else if (intensity != int_q)
      arb = S_INTEN;
    nxt = arb;
    unique case (cur)
      S_IDLE:   nxt = S_TEST;
      S_TEST:   nxt = S_SCAN;
      S_SCAN:   nxt = S_DECODE;
      S_DECODE: nxt = S_INTEN;
      S_INTEN:  nxt = init_done ? arb : S_SHDN;
      default:  nxt = arb;
    endcase
  end

  always_comb begin
    w16  = '0;
    word = '0;
    addr = 4'(dig_n) + 4'd1;
    unique case (nxt)
      S_TEST:   w16 = 16'h0F00;
      S_SCAN:   w16 = {8'h0B, 8'(DIGITS - 1)};
      S_DECODE: w16 = {8'h09, DECODE};
      S_INTEN:  w16 = {8'h0A, 4'h0, intensity};
      S_SHDN:   w16 = {8'h0C, 7'h0, ~shutdown};
      default:  w16 = '0;
    endcase
    // device NUM_DEV-1 sits in the top word so it is shifted first
    for (int d = 0; d < NUM_DEV; d++) begin
      if (nxt == S_DIGIT)
        word[d*16 +: 16] = {4'h0, addr,
          act_src[(d*DIGITS + int'(dig_n))*8 +: 8]};
      else
        word[d*16 +: 16] = w16;
    end
  end

  always_ff @(posedge clk or posedge reset_sw) begin
    if (reset_sw) begin
      cur         <= S_IDLE;
      div         <= '0;
      ph          <= '0;
      dig         <= '0;
      sr          <= '0;
      pend        <= '0;
      act         <= '0;
      int_q       <= '0;
      shd_q       <= 1'b0;
      spi_clk     <= 1'b0;
      dout        <= 1'b0;
      cs          <= 1'b1;
      init_done   <= 1'b0;
      pass_done   <= 1'b0;
      frame_ready <= 1'b1;
    end else begin
      pass_done <= 1'b0;
      if (accept) begin
        pend        <= frame;
        frame_ready <= 1'b0;
      end
      if (xfer) begin
        act         <= pend;
        frame_ready <= 1'b1;
      end
      if (start) begin
        cur     <= nxt;
        div     <= '0;
        ph      <= '0;
        dig     <= dig_n;
        sr      <= word;
        cs      <= 1'b0;
        spi_clk <= 1'b0;
        dout    <= word[L-1];
        if (nxt == S_INTEN)
          int_q <= intensity;
        if (nxt == S_SHDN)
          shd_q <= shutdown;
        if (cur == S_SHDN && !init_done)
          init_done <= 1'b1;
        if (cur == S_DIGIT && last_dig)
          pass_done <= 1'b1;
      end else if (tick) begin
        div <= '0;
        ph  <= ph_n;
        if (ph_n < PHW'(2 * L)) begin
          if (ph_n[0]) begin
            spi_clk <= 1'b1;
          end else begin
            spi_clk <= 1'b0;
            sr      <= sr << 1;
            dout    <= sr[L-2];
          end
        end else begin
          cs      <= 1'b1;
          spi_clk <= 1'b0;
          dout    <= 1'b0;
        end
      end else begin
        div <= div + DW'(1);
      end
    end
  end

endmodule
